redmule_tile_ctrl: RTL and testbench

Host-side control sequencer that drives the control/status interface of one RedMulE tile, acting as the other end of the tile's enable, fetch, IRQ, fence.i and event pins.
- Brings the tile out of idle: tile enable, boot delay, then fetch enable.
- Answers fence.i flush requests and injects IRQs and wake-up pulses.
- Collects tile events and detects end-of-computation, then drains the tile to sleep.
- Sits between the system controller and each redmule_tile instance.

---
 rtl/redmule_tile_ctrl.sv | 176 +++++++++++++++++
 tb/tb_redmule_tile_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_tile_ctrl.sv
// Host-side sequencer for one RedMulE tile: boot, fence.i ack, IRQ/wake injection, event collection, drain.
// Optional RUN-state watchdog is enabled by defining REDMULE_TILE_CTRL_WDOG_EN.
module redmule_tile_ctrl #(
    parameter int BOOT_DELAY = 8,
    parameter int FLUSH_LAT  = 4,
    parameter int N_EVT      = 2,
    parameter int EOC_EVT    = 0,
    parameter int CNT_W      = 16
`ifdef REDMULE_TILE_CTRL_WDOG_EN
    ,
    parameter int WDOG_CYC   = 65535
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             wake_i,
    input  logic             irq_set_i,
    input  logic             irq_clr_i,
    input  logic [4:0]       irq_id_i,
    output logic             tile_enable_o,
    output logic             fetch_enable_o,
    output logic [31:0]      irq_o,
    output logic             wu_wfe_o,
    input  logic             fencei_flush_req_i,
    output logic             fencei_flush_ack_o,
    input  logic             busy_i,
    input  logic             core_sleep_i,
    input  logic [N_EVT-1:0] evt_i,
    output logic [N_EVT-1:0] evt_status_o,
    input  logic [N_EVT-1:0] evt_clr_i,
    output logic [CNT_W-1:0] eoc_cnt_o,
    output logic             done_o,
    output logic [2:0]       state_o,
    output logic             error_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BOOT  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    localparam int BW = $clog2(BOOT_DELAY + 1);
    localparam int FW = $clog2(FLUSH_LAT + 1);
    localparam logic [BW-1:0] BOOT_LAST  = BW'(BOOT_DELAY - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LAT - 1);

    logic [2:0]       state_q, state_d;
    logic [BW-1:0]    boot_cnt_q;
    logic             eoc_q, eoc_rise;
    logic [N_EVT-1:0] evt_status_q;
    logic [CNT_W-1:0] eoc_cnt_q;
    logic [31:0]      irq_q, irq_upd;
    logic             wake_q, wu_q;
    logic             flush_pend_q, flush_armed_q, flush_ack_q;
    logic [FW-1:0]    flush_cnt_q;
    logic             active_q, active_d;
    logic             wdog_expire;

    function automatic logic tile_on(input logic [2:0] s);
        return (s == S_BOOT) || (s == S_RUN) || (s == S_DRAIN);
    endfunction

`ifdef REDMULE_TILE_CTRL_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYC - 1);
    logic [WW-1:0] wdog_cnt_q;

    assign wdog_expire = (state_q == S_RUN) && !(|evt_i) && (wdog_cnt_q == WDOG_LAST);
    assign error_o     = (state_q == S_ERROR);

    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != S_RUN || (|evt_i)) wdog_cnt_q <= '0;
        else                                       wdog_cnt_q <= wdog_cnt_q + 1'b1;
    end
`else
    assign wdog_expire = 1'b0;
    assign error_o     = 1'b0;
`endif

    assign eoc_rise = evt_i[EOC_EVT] & ~eoc_q;
    assign active_q = tile_on(state_q);
    assign active_d = tile_on(state_d);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_BOOT;
            S_BOOT:  if (stop_i) state_d = S_DRAIN;
                     else if (boot_cnt_q == BOOT_LAST) state_d = S_RUN;
            // EOC has priority over the watchdog; EOC and stop both just drain.
            S_RUN:   if (eoc_rise || stop_i) state_d = S_DRAIN;
                     else if (wdog_expire) state_d = S_ERROR;
            S_DRAIN: if (!busy_i && core_sleep_i) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERROR: if (start_i) state_d = S_BOOT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        irq_upd = irq_q;
        if (irq_clr_i) irq_upd[irq_id_i] = 1'b0;
        if (irq_set_i) irq_upd[irq_id_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            boot_cnt_q   <= '0;
            eoc_q        <= 1'b0;
            evt_status_q <= '0;
            eoc_cnt_q    <= '0;
            irq_q        <= '0;
            wake_q       <= 1'b0;
            wu_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            boot_cnt_q   <= (state_q == S_BOOT) ? boot_cnt_q + 1'b1 : '0;
            eoc_q        <= evt_i[EOC_EVT];
            evt_status_q <= (evt_status_q & ~evt_clr_i) | evt_i;
            if (state_q == S_RUN && eoc_rise && eoc_cnt_q != '1)
                eoc_cnt_q <= eoc_cnt_q + 1'b1;
            // Clearing on the transition keeps stale IRQs from resurfacing on the next boot.
            irq_q        <= active_d ? irq_upd : '0;
            wake_q       <= wake_i;
            wu_q         <= (state_q == S_RUN) & wake_i & ~wake_q;
        end
    end

    // Flush: a request must be seen low before another one is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_pend_q  <= 1'b0;
            flush_armed_q <= 1'b1;
            flush_cnt_q   <= '0;
            flush_ack_q   <= 1'b0;
        end else begin
            flush_ack_q <= 1'b0;
            if (!fencei_flush_req_i) flush_armed_q <= 1'b1;
            if (!active_q) begin
                flush_pend_q <= 1'b0;
            end else if (flush_pend_q) begin
                if (!fencei_flush_req_i) begin
                    flush_pend_q <= 1'b0;
                end else if (flush_cnt_q == FLUSH_LAST) begin
                    flush_pend_q <= 1'b0;
                    flush_ack_q  <= 1'b1;
                end else begin
                    flush_cnt_q <= flush_cnt_q + 1'b1;
                end
            end else if (fencei_flush_req_i && flush_armed_q) begin
                flush_armed_q <= 1'b0;
                if (FLUSH_LAT == 1) begin
                    flush_ack_q <= 1'b1;
                end else begin
                    flush_pend_q <= 1'b1;
                    flush_cnt_q  <= FW'(1);
                end
            end
        end
    end

    assign tile_enable_o      = active_q;
    assign fetch_enable_o     = (state_q == S_RUN);
    assign done_o             = (state_q == S_DONE);
    assign state_o            = state_q;
    assign irq_o              = irq_q;
    assign wu_wfe_o           = wu_q;
    assign fencei_flush_ack_o = flush_ack_q & active_q;
    assign evt_status_o       = evt_status_q;
    assign eoc_cnt_o          = eoc_cnt_q;

endmodule

// File: tb/tb_redmule_tile_ctrl.sv
// Scoreboard bench for redmule_tile_ctrl: pulses (ack, done, wake) are checked against queued expectations.
module tb_redmule_tile_ctrl;
    localparam int BOOT_DELAY = 8;
    localparam int FLUSH_LAT  = 4;
    localparam int CNT_W      = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, stop, wake, irq_set, irq_clr, req, busy, sleep;
    logic [4:0] irq_id;
    logic [1:0] evt, evt_clr, evt_status;
    logic tile_en, fetch_en, wu, ack, done, error;
    logic [31:0] irq;
    logic [CNT_W-1:0] eoc_cnt;
    logic [2:0] state;

    int checks = 0, errors = 0, cyc = 0, eoc_exp = 0;
    int ack_q[$], wu_q[$], done_q[$], done_cnt_q[$];
    int mon_e, mon_c;

    redmule_tile_ctrl #(.BOOT_DELAY(BOOT_DELAY), .FLUSH_LAT(FLUSH_LAT), .N_EVT(2), .EOC_EVT(0), .CNT_W(CNT_W)
`ifdef REDMULE_TILE_CTRL_WDOG_EN
        , .WDOG_CYC(100)
`endif
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .wake_i(wake),
        .irq_set_i(irq_set), .irq_clr_i(irq_clr), .irq_id_i(irq_id),
        .tile_enable_o(tile_en), .fetch_enable_o(fetch_en), .irq_o(irq), .wu_wfe_o(wu),
        .fencei_flush_req_i(req), .fencei_flush_ack_o(ack), .busy_i(busy), .core_sleep_i(sleep),
        .evt_i(evt), .evt_status_o(evt_status), .evt_clr_i(evt_clr), .eoc_cnt_o(eoc_cnt),
        .done_o(done), .state_o(state), .error_o(error)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ack === 1'b1) begin
            checks++;
            if (ack_q.size() == 0) begin errors++; $display("FAIL ack_unexpected at cycle %0d, none queued", cyc); end
            else begin mon_e = ack_q.pop_front(); if (cyc !== mon_e) begin errors++; $display("FAIL ack_cycle got %0d want %0d", cyc, mon_e); end end
        end
        if (wu === 1'b1) begin
            checks++;
            if (wu_q.size() == 0) begin errors++; $display("FAIL wu_unexpected at cycle %0d, none queued", cyc); end
            else begin mon_e = wu_q.pop_front(); if (cyc !== mon_e) begin errors++; $display("FAIL wu_cycle got %0d want %0d", cyc, mon_e); end end
        end
        if (done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin errors++; $display("FAIL done_unexpected at cycle %0d, none queued", cyc); end
            else begin
                mon_e = done_q.pop_front(); mon_c = done_cnt_q.pop_front();
                if (cyc !== mon_e || eoc_cnt !== CNT_W'(mon_c)) begin
                    errors++; $display("FAIL done_pulse got cyc=%0d cnt=%0d want cyc=%0d cnt=%0d", cyc, eoc_cnt, mon_e, mon_c);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic boot_to_run();
        start = 1'b1; step(1); start = 1'b0; step(BOOT_DELAY);
    endtask

    task automatic finish_run();
        done_q.push_back(cyc + 2); done_cnt_q.push_back(eoc_exp);
        stop = 1'b1; step(1); stop = 1'b0; step(2);
    endtask

    task automatic test_reset();
        rst = 1'b1; step(2);
        checks++; if ({tile_en, fetch_en, wu, ack, done, error} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b want 000000", {tile_en, fetch_en, wu, ack, done, error}); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if ({irq, evt_status, eoc_cnt} !== '0) begin errors++; $display("FAIL reset_regs got irq=%h evt=%b cnt=%0d want 0", irq, evt_status, eoc_cnt); end
        rst = 1'b0; eoc_exp = 0; step(2);
    endtask

    task automatic test_boot();
        int s;
        stop = 1'b1; step(1); stop = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_stop got %0d want 0", state); end
        s = cyc; start = 1'b1; step(1); start = 1'b0;
        checks++; if ({tile_en, fetch_en, state} !== {2'b10, 3'd1}) begin errors++; $display("FAIL boot_entry got te=%b fe=%b st=%0d want 1 0 1 at %0d", tile_en, fetch_en, state, s + 1); end
        step(BOOT_DELAY - 1);
        checks++; if ({fetch_en, state} !== {1'b0, 3'd1}) begin errors++; $display("FAIL boot_last got fe=%b st=%0d want 0 1", fetch_en, state); end
        step(1);
        checks++; if ({tile_en, fetch_en, state} !== {2'b11, 3'd2}) begin errors++; $display("FAIL run_entry got te=%b fe=%b st=%0d want 1 1 2", tile_en, fetch_en, state); end
    endtask

    task automatic test_eoc();
        busy = 1'b1; sleep = 1'b0;
        eoc_exp = 1; done_q.push_back(cyc + 6); done_cnt_q.push_back(eoc_exp);
        evt = 2'b01; step(1); evt = 2'b00;
        checks++; if ({tile_en, fetch_en, state} !== {2'b10, 3'd3}) begin errors++; $display("FAIL eoc_drain got te=%b fe=%b st=%0d want 1 0 3", tile_en, fetch_en, state); end
        checks++; if (eoc_cnt !== 2'd1) begin errors++; $display("FAIL eoc_count got %0d want 1", eoc_cnt); end
        step(4); busy = 1'b0; sleep = 1'b1; step(1);
        checks++; if ({tile_en, state} !== {1'b0, 3'd4}) begin errors++; $display("FAIL eoc_done got te=%b st=%0d want 0 4", tile_en, state); end
        step(1);
        checks++; if ({done, state} !== {1'b0, 3'd0}) begin errors++; $display("FAIL eoc_idle got done=%b st=%0d want 0 0", done, state); end
    endtask

    task automatic test_events();
        evt_clr = 2'b11; step(1); evt_clr = 2'b00;
        checks++; if (evt_status !== 2'b00) begin errors++; $display("FAIL evt_clear got %b want 00", evt_status); end
        evt = 2'b10; step(1); evt = 2'b00; step(1);
        checks++; if (evt_status !== 2'b10) begin errors++; $display("FAIL evt_sticky got %b want 10", evt_status); end
        evt = 2'b10; evt_clr = 2'b10; step(1); evt = 2'b00; evt_clr = 2'b00;
        checks++; if (evt_status !== 2'b10) begin errors++; $display("FAIL evt_set_wins got %b want 10", evt_status); end
        evt_clr = 2'b10; step(1); evt_clr = 2'b00;
        checks++; if (evt_status !== 2'b00) begin errors++; $display("FAIL evt_clr_only got %b want 00", evt_status); end
    endtask

    task automatic test_flush();
        boot_to_run();
        ack_q.push_back(cyc + FLUSH_LAT);
        req = 1'b1; step(6); req = 1'b0; step(1);
        req = 1'b1; step(2); req = 1'b0; step(5);
        ack_q.push_back(cyc + FLUSH_LAT);
        req = 1'b1; step(5); req = 1'b0; step(1);
        checks++; if (ack_q.size() != 0) begin errors++; $display("FAIL flush_run_ack_missing got %0d pending want 0", ack_q.size()); end
        finish_run();
        req = 1'b1; step(FLUSH_LAT);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL flush_idle got %b want 0", ack); end
        step(2); req = 1'b0; step(1);
    endtask

    task automatic test_irq_wake();
        wake = 1'b1; step(1);
        checks++; if (wu !== 1'b0) begin errors++; $display("FAIL wake_idle got %b want 0", wu); end
        step(1); wake = 1'b0;
        irq_set = 1'b1; irq_id = 5'd3; step(1); irq_set = 1'b0;
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL irq_idle got %h want 0", irq); end
        boot_to_run();
        irq_set = 1'b1; irq_id = 5'd3; step(1);
        checks++; if (irq !== 32'h8) begin errors++; $display("FAIL irq_set got %h want 8", irq); end
        irq_clr = 1'b1; step(1);
        checks++; if (irq !== 32'h8) begin errors++; $display("FAIL irq_set_wins got %h want 8", irq); end
        irq_set = 1'b0; step(1);
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL irq_clr got %h want 0", irq); end
        irq_clr = 1'b0; irq_set = 1'b1; irq_id = 5'd31; step(1); irq_set = 1'b0;
        checks++; if (irq !== 32'h8000_0000) begin errors++; $display("FAIL irq_set31 got %h want 80000000", irq); end
        wu_q.push_back(cyc + 1);
        wake = 1'b1; step(3); wake = 1'b0; step(1);
        finish_run();
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL irq_forced_off got %h want 0", irq); end
    endtask

    task automatic test_stop();
        start = 1'b1; step(1); start = 1'b0;
        done_q.push_back(cyc + 2); done_cnt_q.push_back(eoc_exp);
        stop = 1'b1; step(1); stop = 1'b0;
        checks++; if ({tile_en, fetch_en, state} !== {2'b10, 3'd3}) begin errors++; $display("FAIL stop_boot got te=%b fe=%b st=%0d want 1 0 3", tile_en, fetch_en, state); end
        step(2);
        boot_to_run();
        eoc_exp = 2; done_q.push_back(cyc + 2); done_cnt_q.push_back(eoc_exp);
        stop = 1'b1; evt = 2'b01; step(1); stop = 1'b0; evt = 2'b00;
        checks++; if ({eoc_cnt, state} !== {2'd2, 3'd3}) begin errors++; $display("FAIL stop_eoc got cnt=%0d st=%0d want 2 3", eoc_cnt, state); end
        step(2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            boot_to_run();
            eoc_exp = (eoc_exp < 3) ? eoc_exp + 1 : 3;
            done_q.push_back(cyc + 2); done_cnt_q.push_back(eoc_exp);
            evt = 2'b01; step(1); evt = 2'b00;
            checks++; if (eoc_cnt !== CNT_W'(eoc_exp)) begin errors++; $display("FAIL eoc_sat run %0d got %0d want %0d", i, eoc_cnt, eoc_exp); end
            step(1); start = 1'b1; step(1); start = 1'b0;
            checks++; if (state !== 3'd0) begin errors++; $display("FAIL done_start_ignored run %0d got %0d want 0", i, state); end
            step(1);
        end
    endtask

    task automatic test_reset_mid_run();
        boot_to_run();
        irq_set = 1'b1; irq_id = 5'd5; evt = 2'b10; step(1); irq_set = 1'b0; evt = 2'b00;
        rst = 1'b1; step(1); rst = 1'b0; eoc_exp = 0;
        checks++; if ({tile_en, fetch_en, wu, ack, done, error, state} !== 9'b0) begin errors++; $display("FAIL rst_mid_flags got %b want 0", {tile_en, fetch_en, wu, ack, done, error, state}); end
        checks++; if ({irq, evt_status, eoc_cnt} !== '0) begin errors++; $display("FAIL rst_mid_regs got irq=%h evt=%b cnt=%0d want 0", irq, evt_status, eoc_cnt); end
        step(1); start = 1'b1; step(1); start = 1'b0;
        checks++; if ({tile_en, state} !== {1'b1, 3'd1}) begin errors++; $display("FAIL reboot_boot got te=%b st=%0d want 1 1", tile_en, state); end
        step(BOOT_DELAY);
        checks++; if ({fetch_en, state} !== {1'b1, 3'd2}) begin errors++; $display("FAIL reboot_run got fe=%b st=%0d want 1 2", fetch_en, state); end
        finish_run();
    endtask

`ifdef REDMULE_TILE_CTRL_WDOG_EN
    task automatic test_watchdog();
        boot_to_run(); step(99);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL wdog_early got %0d want 2", state); end
        step(1);
        checks++; if ({error, tile_en, fetch_en, state} !== {3'b100, 3'd5}) begin errors++; $display("FAIL wdog_error got err=%b te=%b fe=%b st=%0d want 1 0 0 5", error, tile_en, fetch_en, state); end
        step(3);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL wdog_sticky got %b want 1", error); end
        start = 1'b1; step(1); start = 1'b0;
        checks++; if ({error, state} !== {1'b0, 3'd1}) begin errors++; $display("FAIL wdog_restart got err=%b st=%0d want 0 1", error, state); end
        step(BOOT_DELAY); finish_run();
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; wake = 1'b0; irq_set = 1'b0; irq_clr = 1'b0;
        irq_id = 5'd0; req = 1'b0; busy = 1'b0; sleep = 1'b1; evt = 2'b00; evt_clr = 2'b00;
        test_reset();
        test_boot();
        test_eoc();
        test_events();
        test_flush();
        test_irq_wake();
        test_stop();
        test_back_to_back();
        test_reset_mid_run();
`ifdef REDMULE_TILE_CTRL_WDOG_EN
        test_watchdog();
`endif
        step(3);
        checks++; if (ack_q.size() + wu_q.size() + done_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d/%0d/%0d pending want 0/0/0", ack_q.size(), wu_q.size(), done_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
